// File: rtl/alu_program_sequencer.sv
// Microprogram sequencer feeding the 4-bit accumulator ALU: holds a 16-entry
// {opcode,operand} program and issues one instruction per clock, with JNZ/HALT control opcodes.
module alu_program_sequencer #(
    parameter int DEPTH          = 16,
    parameter int MAX_STEPS      = 255,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_wdata,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] alu_c,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] result,
    output logic [3:0] pc
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_JNZ   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b0110;
    localparam logic [3:0] OP_RESET = 4'b1111;
    localparam logic [3:0] LAST_PC  = 4'(DEPTH - 1);
    localparam logic [7:0] STEP_LIM = 8'(MAX_STEPS);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN} state_t;

    state_t     r_state, w_nxt_state;
    logic [7:0] r_mem [DEPTH];
    logic [3:0] r_pc, w_nxt_pc;
    logic [7:0] r_steps, w_nxt_steps;
    logic [3:0] r_opc, w_nxt_opc;
    logic [3:0] r_a, w_nxt_a;
    logic       r_done, w_nxt_done;
    logic       r_err, w_nxt_err;
    logic [3:0] r_result, w_nxt_result;
    logic       r_hpend, w_nxt_hpend;   // entry 15 executed: halt on the next edge

    logic [7:0] w_instr;
    logic [3:0] w_op;
    logic [3:0] w_arg;

    assign w_instr = r_mem[r_pc];
    assign w_op    = w_instr[7:4];
    assign w_arg   = w_instr[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h60;
        end else if (r_state == S_IDLE && prog_we) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_pc     = r_pc;
        w_nxt_steps  = r_steps;
        w_nxt_opc    = r_opc;
        w_nxt_a      = r_a;
        w_nxt_done   = 1'b0;
        w_nxt_err    = r_err;
        w_nxt_result = r_result;
        w_nxt_hpend  = r_hpend;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_pc    = 4'd0;
                    w_nxt_steps = 8'd0;
                    w_nxt_err   = 1'b0;
                    w_nxt_hpend = 1'b0;
                    w_nxt_a     = 4'd0;
                    if (CLEAR_ON_START) begin
                        w_nxt_state = S_CLR;
                        w_nxt_opc   = OP_RESET;
                    end else begin
                        w_nxt_state = S_RUN;
                        w_nxt_opc   = OP_NOP;
                    end
                end
            end
            S_CLR: begin
                w_nxt_opc   = OP_NOP;
                w_nxt_a     = 4'd0;
                w_nxt_state = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                w_nxt_opc = OP_NOP;
                w_nxt_a   = 4'd0;
                if (abort) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_hpend = 1'b0;
                end else if (r_hpend || w_op == OP_HALT) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_result = alu_c;
                    w_nxt_done   = 1'b1;
                    w_nxt_hpend  = 1'b0;
                end else if (r_steps == STEP_LIM) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_result = alu_c;
                    w_nxt_done   = 1'b1;
                    w_nxt_err    = 1'b1;
                end else begin
                    w_nxt_steps = r_steps + 8'd1;
                    if (w_op == OP_JNZ && alu_c != 4'd0) begin
                        w_nxt_pc = w_arg;
                    end else begin
                        if (w_op != OP_JNZ) begin
                            w_nxt_opc = w_op;
                            w_nxt_a   = w_arg;
                        end
                        // No wrap past the last entry: finish with an implicit halt
                        if (r_pc == LAST_PC) w_nxt_hpend = 1'b1;
                        else                 w_nxt_pc    = r_pc + 4'd1;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= 4'd0;
            r_steps  <= 8'd0;
            r_opc    <= OP_NOP;
            r_a      <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 4'd0;
            r_hpend  <= 1'b0;
        end else begin
            r_pc     <= w_nxt_pc;
            r_steps  <= w_nxt_steps;
            r_opc    <= w_nxt_opc;
            r_a      <= w_nxt_a;
            r_done   <= w_nxt_done;
            r_err    <= w_nxt_err;
            r_result <= w_nxt_result;
            r_hpend  <= w_nxt_hpend;
        end
    end

    assign alu_opcode = r_opc;
    assign alu_a      = r_a;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign result     = r_result;
    assign pc         = r_pc;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Bench for alu_program_sequencer: a breadboard ALU model closes the loop on alu_c and a
// program-level interpreter predicts the issued op stream, result and err of each run.
module tb_alu_program_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'd0;
    logic [7:0] prog_wdata = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] alu_c;
    logic [3:0] alu_opcode;
    logic [3:0] alu_a;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] result;
    logic [3:0] pc;

    alu_program_sequencer #(.DEPTH(16), .MAX_STEPS(255), .CLEAR_ON_START(1'b1)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .abort(abort), .alu_c(alu_c),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .busy(busy), .done(done),
        .err(err), .result(result), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] c, input logic [3:0] op,
                                         input logic [3:0] a);
        case (op)
            4'h1:    return c + a;
            4'h2:    return c - a;
            4'h3:    return 4'(c * a);
            4'h4:    return c & a;
            4'h7:    return c | a;
            4'h8:    return c ^ a;
            4'hE:    return a;
            4'hF:    return 4'd0;
            default: return c;
        endcase
    endfunction

    // Breadboard accumulator: C is combinational, latched into acc at each edge
    logic [3:0] acc = 4'd0;
    always_comb alu_c = alu_f(acc, alu_opcode, alu_a);
    always @(posedge clk) acc <= alu_c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] prog [16];
    logic [7:0] exp_q [$];
    logic [3:0] exp_result;
    logic       exp_err;
    logic [3:0] last_result = 4'd0;

    // Interpret the program: accumulator starts at 0 after the clear cycle
    task automatic model_run();
        int pc_m = 0;
        int steps = 0;
        bit pend = 0;
        bit fin = 0;
        logic [3:0] m = 4'd0;
        logic [3:0] op, arg;
        exp_q.delete();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h00);
        while (!fin) begin
            op  = prog[pc_m][7:4];
            arg = prog[pc_m][3:0];
            if (pend || op == 4'h6) begin
                exp_q.push_back(8'h00); exp_result = m; exp_err = 1'b0; fin = 1;
            end else if (steps == 255) begin
                exp_q.push_back(8'h00); exp_result = m; exp_err = 1'b1; fin = 1;
            end else begin
                steps++;
                if (op == 4'h5) exp_q.push_back(8'h00);
                else begin
                    exp_q.push_back({op, arg});
                    m = alu_f(m, op, arg);
                end
                if (op == 4'h5 && m != 4'd0) pc_m = int'(arg);
                else if (pc_m == 15)         pend = 1;
                else                         pc_m++;
            end
        end
    endtask

    // Write all 16 entries; optionally the last write shares its edge with start
    task automatic load_prog(input bit with_start);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i];
            start = with_start && (i == 15);
        end
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit load);
        int last;
        if (load) load_prog(1'b1);
        else begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        model_run();
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, " op/a"}, 32'({alu_opcode, alu_a}), 32'(exp_q[i]));
            chk({tag, " done"}, 32'(done), 32'(i == last));
            chk({tag, " busy"}, 32'(busy), 32'(i != last));
            chk({tag, " err"},  32'(err),  32'((i == last) ? exp_err : 1'b0));
        end
        chk({tag, " result"}, 32'(result), 32'(exp_result));
        last_result = exp_result;
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, " a"},      32'(alu_a),      32'd0);
        chk({tag, " busy"},   32'(busy),       32'd0);
        chk({tag, " done"},   32'(done),       32'd0);
        chk({tag, " err"},    32'(err),        32'd0);
        chk({tag, " result"}, 32'(result),     32'd0);
        chk({tag, " pc"},     32'(pc),         32'd0);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) prog[i] = 8'h60;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_low");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_idle");

        fill_halt();
        prog[0] = 8'hE5; prog[1] = 8'h33; prog[2] = 8'h60;
        run_check("t2", 1'b1);
        chk("t2 result15", 32'(result), 32'd15);

        fill_halt();
        prog[0] = 8'hE3; prog[1] = 8'h21; prog[2] = 8'h51; prog[3] = 8'h60;
        run_check("t3", 1'b1);
        chk("t3 result0", 32'(result), 32'd0);

        fill_halt();
        prog[0] = 8'hE1; prog[1] = 8'h50;
        run_check("t4", 1'b1);
        chk("t4 err", 32'(err), 32'd1);

        // Abort at step 2, with write/start attempts while busy
        fill_halt();
        prog[0] = 8'hE5; prog[1] = 8'h33; prog[2] = 8'h21; prog[3] = 8'h12;
        load_prog(1'b0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 8'h11; start = 1'b1;
        @(negedge clk);
        chk("t5 busy before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; prog_we = 1'b0; start = 1'b0;
        chk("t5 busy", 32'(busy), 32'd0);
        chk("t5 done", 32'(done), 32'd0);
        chk("t5 op/a", 32'({alu_opcode, alu_a}), 32'd0);
        chk("t5 result", 32'(result), 32'(last_result));
        @(negedge clk);
        chk("t5 done late", 32'(done), 32'd0);
        run_check("t5 rerun", 1'b0);

        // Abort on the same edge as a HALT fetch
        fill_halt();
        load_prog(1'b0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abt_halt done", 32'(done), 32'd0);
        chk("abt_halt busy", 32'(busy), 32'd0);
        chk("abt_halt result", 32'(result), 32'(last_result));

        // Asynchronous reset between edges mid-run
        prog[0] = 8'hE1; prog[1] = 8'h50;
        load_prog(1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("t6 async");
        @(negedge clk); rst = 1'b1;
        fill_halt();
        run_check("t6 post", 1'b0);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                int sel = int'($urandom_range(0, 9));
                logic [3:0] arg = 4'($urandom_range(0, 15));
                logic [3:0] ops [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hE, 4'h0};
                if (sel == 0)      prog[i] = {4'h6, arg};
                else if (sel == 1) prog[i] = {4'h5, arg};
                else               prog[i] = {ops[$urandom_range(0, 7)], arg};
            end
            run_check($sformatf("rnd%0d", r), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
